// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one fixed-latency single-port synchronous memory between
//             the instruction-fetch port (I) and the data load/store port (D).
//             Only one transaction is in flight at a time. Contention goes to
//             D, or alternates between the ports when MEM_ARB_RR_EN is defined.
//  Options  : MEM_ARB_RR_EN - round-robin arbitration on simultaneous requests
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ready,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_ready,
  output logic [DW-1:0]   d_rdata,
  output logic            m_en,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_wstrb,
  input  logic [DW-1:0]   m_rdata
);

  localparam int CW = 4;  // latency counter width, covers MEM_LAT up to 15
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              gnt_q, gnt_d;      // winner of the latest grant: 1 = D, 0 = I
  logic              m_we_q, m_we_d;
  logic [AW-1:0]     m_addr_q, m_addr_d;
  logic [DW-1:0]     m_wdata_q, m_wdata_d;
  logic [DW/8-1:0]   m_wstrb_q, m_wstrb_d;
  logic              pick_d;
  logic              done;

`ifdef MEM_ARB_RR_EN
  // On contention serve the port that did not win last time.
  assign pick_d = d_req & (~i_req | ~gnt_q);
`else
  // D always beats I.
  assign pick_d = d_req;
`endif

  // The access completes in the WAIT cycle where the counter has drained.
  assign done    = (state_q == WAIT) && (cnt_q == '0);
  assign i_ready = done & ~gnt_q;
  assign d_ready = done &  gnt_q;
  // A store still returns whatever the memory drives, so force it to zero.
  assign i_rdata = i_ready ? m_rdata : '0;
  assign d_rdata = (d_ready && !m_we_q) ? m_rdata : '0;
  assign m_en    = (state_q == ISSUE);
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;

  // State, counter, grant and memory-side command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gnt_q     <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

  // Next-state logic; command registers only change on a grant so they hold
  // steady from ISSUE through WAIT for a late-sampling memory.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d   = pick_d;
          state_d = ISSUE;
          if (pick_d) begin
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_we ? d_wstrb : '0;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            m_wstrb_d = '0;
          end
        end
      end
      ISSUE: begin
        cnt_d   = C_CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Scoreboard bench for mem_arbiter: stimulus phases push expected
//             ready responses and memory commands; a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { bit port; logic [31:0] data; int cyc; } exp_t;        // port 1 = D
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } cmd_t;

  exp_t exp_q[$];
  cmd_t mexp_q[$];
  cmd_t i_q[$];
  cmd_t d_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: data is presented LAT cycles after m_en, computed from the
  // address seen at that late cycle so a moving m_addr shows up as bad data.
  logic [LAT-1:0] pipe;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= (pipe << 1) | LAT'(m_en);
  end
  always_comb begin
    if (!pipe[LAT-1])            m_rdata = 32'hBAD0BAD0;
    else if (m_addr == 32'h100)  m_rdata = 32'h00000513;
    else                         m_rdata = m_addr ^ 32'h12345678;
  end

  // Monitor: pops expected responses and memory commands as the DUT shows them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_ready && d_ready) chk("both_ready", 1, 0);
      if (!i_ready && i_rdata != 0) chk("i_rdata_idle", i_rdata, 0);
      if (!d_ready && d_rdata != 0) chk("d_rdata_idle", d_rdata, 0);
      if (i_ready || d_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", {i_ready, d_ready}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ready_port", d_ready, e.port);
          chk("rdata", d_ready ? d_rdata : i_rdata, e.data);
          chk("ready_cycle", cyc, e.cyc);
        end
      end
      if (m_en) begin
        if (mexp_q.size() == 0) begin
          chk("unexpected_m_en", m_en, 0);
        end else begin
          cmd_t c;
          c = mexp_q.pop_front();
          chk("m_addr", m_addr, c.addr);
          chk("m_we", m_we, c.we);
          chk("m_wstrb", m_wstrb, c.wstrb);
          if (c.we) chk("m_wdata", m_wdata, c.wdata);
        end
      end
    end
  end

  task automatic expect_tx(input bit port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [31:0] rdata, input int rcyc);
    exp_t e;
    cmd_t c;
    e.port = port; e.data = rdata; e.cyc = rcyc;
    c.we = we; c.addr = addr; c.wdata = wdata; c.wstrb = wstrb;
    exp_q.push_back(e);
    mexp_q.push_back(c);
  endtask

  task automatic wait_ready(input bit port, input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (port ? d_ready : i_ready) break;
      n++;
      if (n > 200) begin
        chk(name, 0, 1);
        break;
      end
    end
  endtask

  // Fetch requester: holds each request until its ready, then replaces or drops.
  task automatic run_i();
    while (i_q.size() > 0) begin
      i_req  = 1'b1;
      i_addr = i_q[0].addr;
      wait_ready(1'b0, "i_timeout");
      @(posedge clk); #1;
      void'(i_q.pop_front());
    end
    i_req  = 1'b0;
    i_addr = '0;
  endtask

  task automatic run_d();
    while (d_q.size() > 0) begin
      d_req   = 1'b1;
      d_we    = d_q[0].we;
      d_addr  = d_q[0].addr;
      d_wdata = d_q[0].wdata;
      d_wstrb = d_q[0].wstrb;
      wait_ready(1'b1, "d_timeout");
      @(posedge clk); #1;
      void'(d_q.pop_front());
    end
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
  endtask

  task automatic push_req(input bit port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.wstrb = wstrb;
    if (port) d_q.push_back(c);
    else      i_q.push_back(c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  localparam int STEP = LAT + 2;   // cycles per back-to-back transaction
  int t;
  int seen;

  initial begin
    // Reset state
    #12;
    chk("rst_m_en", m_en, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wstrb", m_wstrb, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single fetch
    #1 t = cyc;
    push_req(1'b0, 1'b0, 32'h100, '0, '0);
    expect_tx(1'b0, 1'b0, 32'h100, '0, 4'h0, 32'h00000513, t + 1 + LAT);
    run_i();
    drain();

    // Store
    @(posedge clk); #1 t = cyc;
    push_req(1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF);
    expect_tx(1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'hF, 32'h0, t + 1 + LAT);
    run_d();
    drain();

    // Load with stray strobes: memory must see zero strobes
    @(posedge clk); #1 t = cyc;
    push_req(1'b1, 1'b0, 32'h3000, 32'h55555555, 4'hF);
    expect_tx(1'b1, 1'b0, 32'h3000, '0, 4'h0, 32'h12346678, t + 1 + LAT);
    run_d();
    drain();

    // Reset during WAIT: command dropped, no ready ever issued
    @(posedge clk); #1 t = cyc;
    mexp_q.push_back('{we: 1'b0, addr: 32'h3000, wdata: '0, wstrb: 4'h0});
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_en", m_en, 0);
    chk("midrst_d_ready", d_ready, 0);
    chk("midrst_i_ready", i_ready, 0);
    chk("midrst_m_addr", m_addr, 0);
    d_req = 1'b0; d_addr = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (i_ready || d_ready) seen++;
    end
    chk("no_ready_after_rst", seen, 0);

    // Fresh fetch after reset with normal latency
    @(posedge clk); #1 t = cyc;
    push_req(1'b0, 1'b0, 32'h100, '0, '0);
    expect_tx(1'b0, 1'b0, 32'h100, '0, 4'h0, 32'h00000513, t + 1 + LAT);
    run_i();
    drain();

    // Contention: D first (last grant is I in both builds), then I
    @(posedge clk); #1 t = cyc;
    push_req(1'b0, 1'b0, 32'h104, '0, '0);
    push_req(1'b1, 1'b0, 32'h10, '0, '0);
    expect_tx(1'b1, 1'b0, 32'h10,  '0, 4'h0, 32'h12345668, t + 1 + LAT);
    expect_tx(1'b0, 1'b0, 32'h104, '0, 4'h0, 32'h1234577C, t + 1 + LAT + STEP);
    fork run_i(); run_d(); join
    drain();

    // Four back-to-back contending transactions per port
    @(posedge clk); #1 t = cyc;
    push_req(1'b1, 1'b0, 32'h40, '0, '0);
    push_req(1'b1, 1'b0, 32'h44, '0, '0);
    push_req(1'b1, 1'b0, 32'h48, '0, '0);
    push_req(1'b1, 1'b0, 32'h4C, '0, '0);
    push_req(1'b0, 1'b0, 32'h200, '0, '0);
    push_req(1'b0, 1'b0, 32'h204, '0, '0);
    push_req(1'b0, 1'b0, 32'h208, '0, '0);
    push_req(1'b0, 1'b0, 32'h20C, '0, '0);
`ifdef MEM_ARB_RR_EN
    expect_tx(1'b1, 1'b0, 32'h40,  '0, 4'h0, 32'h12345638, t + 1 + LAT + 0*STEP);
    expect_tx(1'b0, 1'b0, 32'h200, '0, 4'h0, 32'h12345478, t + 1 + LAT + 1*STEP);
    expect_tx(1'b1, 1'b0, 32'h44,  '0, 4'h0, 32'h1234563C, t + 1 + LAT + 2*STEP);
    expect_tx(1'b0, 1'b0, 32'h204, '0, 4'h0, 32'h1234547C, t + 1 + LAT + 3*STEP);
    expect_tx(1'b1, 1'b0, 32'h48,  '0, 4'h0, 32'h12345630, t + 1 + LAT + 4*STEP);
    expect_tx(1'b0, 1'b0, 32'h208, '0, 4'h0, 32'h12345470, t + 1 + LAT + 5*STEP);
    expect_tx(1'b1, 1'b0, 32'h4C,  '0, 4'h0, 32'h12345634, t + 1 + LAT + 6*STEP);
    expect_tx(1'b0, 1'b0, 32'h20C, '0, 4'h0, 32'h12345474, t + 1 + LAT + 7*STEP);
`else
    expect_tx(1'b1, 1'b0, 32'h40,  '0, 4'h0, 32'h12345638, t + 1 + LAT + 0*STEP);
    expect_tx(1'b1, 1'b0, 32'h44,  '0, 4'h0, 32'h1234563C, t + 1 + LAT + 1*STEP);
    expect_tx(1'b1, 1'b0, 32'h48,  '0, 4'h0, 32'h12345630, t + 1 + LAT + 2*STEP);
    expect_tx(1'b1, 1'b0, 32'h4C,  '0, 4'h0, 32'h12345634, t + 1 + LAT + 3*STEP);
    expect_tx(1'b0, 1'b0, 32'h200, '0, 4'h0, 32'h12345478, t + 1 + LAT + 4*STEP);
    expect_tx(1'b0, 1'b0, 32'h204, '0, 4'h0, 32'h1234547C, t + 1 + LAT + 5*STEP);
    expect_tx(1'b0, 1'b0, 32'h208, '0, 4'h0, 32'h12345470, t + 1 + LAT + 6*STEP);
    expect_tx(1'b0, 1'b0, 32'h20C, '0, 4'h0, 32'h12345474, t + 1 + LAT + 7*STEP);
`endif
    fork run_i(); run_d(); join
    drain();

    repeat (4) @(posedge clk);
    chk("mexp_empty", mexp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
